// File: rtl/serial_add_sub_unit.sv
// -----------------------------------------------------------------------------
// serial_add_sub_unit
//
// Bit-serial, LSB-first two's-complement adder/subtractor.
// It computes s = a + b or s = a - b over WIDTH clock cycles and uses a
// start/done handshake. The operand pair is kept in registers alongside the
// result, so a downstream overflow stage can sample a_out, b_eff and s
// directly. b_eff holds the operand exactly as it was added (b, or ~b for a
// subtract), so the sign-bit overflow rule still applies when subtracting.
//
// Optional feature macro: OVF_FLAG_EN
//   When defined, the ovf output is present. It is computed as
//   carry_into_MSB ^ carry_out_of_MSB.
//   When undefined, the port and its logic are absent.
//
// Parameters
//   WIDTH   operand/result width in bits (>= 2), default 8
//
// Ports
//   clk     in   rising-edge clock
//   rst     in   synchronous active-high reset
//   start   in   operation request, sampled only while idle
//   sub     in   0 = add, 1 = subtract (sampled with start)
//   a       in   operand A (sampled with start)
//   b       in   operand B (sampled with start)
//   busy    out  high while bits are being processed
//   done    out  one-cycle pulse, results valid
//   s       out  sum/difference modulo 2^WIDTH
//   cout    out  carry out of the MSB (subtract: 1 = no borrow)
//   a_out   out  registered A
//   b_eff   out  registered effective B (b or ~b)
//   ovf     out  signed overflow flag (OVF_FLAG_EN only)
// -----------------------------------------------------------------------------
module serial_add_sub_unit #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic [WIDTH-1:0] a_out,
    output logic [WIDTH-1:0] b_eff
`ifdef OVF_FLAG_EN
    ,
    output logic             ovf
`endif
);

    localparam int               CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t state_q, state_d;

    // Datapath registers
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             cout_q, cout_d;
    logic [WIDTH-1:0] a_out_q, a_out_d;
    logic [WIDTH-1:0] b_eff_q, b_eff_d;
`ifdef OVF_FLAG_EN
    logic             ovf_q, ovf_d;
`endif

    logic             accept;
    logic             last_bit;
    logic             sum_bit;
    logic             carry_gen;
    logic [WIDTH-1:0] b_op;
    logic [WIDTH-1:0] s_shift;
    logic [WIDTH-1:0] a_shift;
    logic [WIDTH-1:0] b_shift;

    // -------------------------------------------------------------------------
    // One-bit full adder on the current LSBs of the shift copies
    // -------------------------------------------------------------------------
    assign sum_bit   = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
    assign carry_gen = (a_sh_q[0] & b_sh_q[0]) | (carry_q & (a_sh_q[0] ^ b_sh_q[0]));

    // A subtract is an add of the inverted operand with the carry-in preset to 1.
    assign b_op      = sub ? ~b : b;

    assign accept    = (state_q == ST_IDLE) && start;
    assign last_bit  = (state_q == ST_SHIFT) && (cnt_q == CNT_LAST);

    // -------------------------------------------------------------------------
    // Shift wiring.
    // The result enters at the MSB, so after WIDTH steps bit 0 of the sum has
    // reached s[0]. The operand copies drain towards the LSB and are zero-filled.
    // -------------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH - 1; gi++) begin : g_shift
            assign s_shift[gi] = s_q[gi+1];
            assign a_shift[gi] = a_sh_q[gi+1];
            assign b_shift[gi] = b_sh_q[gi+1];
        end
    endgenerate

    assign s_shift[WIDTH-1] = sum_bit;
    assign a_shift[WIDTH-1] = 1'b0;
    assign b_shift[WIDTH-1] = 1'b0;

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_DONE;
                end
            end
            // The done pulse always lasts exactly one cycle.
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: outputs
    // -------------------------------------------------------------------------
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state_q)
            ST_SHIFT: busy = 1'b1;
            ST_DONE:  done = 1'b1;
            default: begin
                busy = 1'b0;
                done = 1'b0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Datapath next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        cnt_d   = cnt_q;
        carry_d = carry_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        s_d     = s_q;
        cout_d  = cout_q;
        a_out_d = a_out_q;
        b_eff_d = b_eff_q;
`ifdef OVF_FLAG_EN
        ovf_d   = ovf_q;
`endif

        if (accept) begin
            // The registered operands change at once. s, cout and ovf keep
            // their old values until the shifting overwrites them.
            a_out_d = a;
            b_eff_d = b_op;
            a_sh_d  = a;
            b_sh_d  = b_op;
            carry_d = sub;
            cnt_d   = '0;
        end else if (state_q == ST_SHIFT) begin
            s_d     = s_shift;
            a_sh_d  = a_shift;
            b_sh_d  = b_shift;
            carry_d = carry_gen;
            cnt_d   = cnt_q + 1'b1;
            if (last_bit) begin
                cnt_d  = '0;
                cout_d = carry_gen;
`ifdef OVF_FLAG_EN
                // On the MSB step, carry_q is the carry into the MSB.
                ovf_d  = carry_q ^ carry_gen;
`endif
            end
        end
    end

    // -------------------------------------------------------------------------
    // Datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            carry_q <= 1'b0;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            s_q     <= '0;
            cout_q  <= 1'b0;
            a_out_q <= '0;
            b_eff_q <= '0;
`ifdef OVF_FLAG_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            s_q     <= s_d;
            cout_q  <= cout_d;
            a_out_q <= a_out_d;
            b_eff_q <= b_eff_d;
`ifdef OVF_FLAG_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign s     = s_q;
    assign cout  = cout_q;
    assign a_out = a_out_q;
    assign b_eff = b_eff_q;
`ifdef OVF_FLAG_EN
    assign ovf   = ovf_q;
`endif

endmodule

// File: tb/tb_serial_add_sub_unit.sv
// -----------------------------------------------------------------------------
// tb_serial_add_sub_unit
//
// Self-checking bench for serial_add_sub_unit (WIDTH = 8).
// A behavioural model computes each result with plain wide arithmetic and
// tracks the handshake purely from latency: done follows an accept by WIDTH
// edges and lasts one cycle. A compare process checks the DUT against the
// model on every falling edge. Directed cases pin the model to hand-computed
// values, and a randomized phase follows.
// -----------------------------------------------------------------------------
module tb_serial_add_sub_unit;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] s;
    logic         cout;
    logic [W-1:0] a_out;
    logic [W-1:0] b_eff;
`ifdef OVF_FLAG_EN
    logic         ovf;
`endif

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    serial_add_sub_unit #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .sub   (sub),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .s     (s),
        .cout  (cout),
        .a_out (a_out),
        .b_eff (b_eff)
`ifdef OVF_FLAG_EN
        ,
        .ovf   (ovf)
`endif
    );

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endfunction

    // Reference arithmetic: s = (a + b_eff + sub) mod 2^W.
    function automatic void model_calc(input logic [W-1:0] av, input logic [W-1:0] bv, input logic subv,
                                       output logic [W-1:0] sv, output logic cv, output logic vv,
                                       output logic [W-1:0] bev);
        logic [W:0] full;
        bev  = subv ? ~bv : bv;
        full = {1'b0, av} + {1'b0, bev} + (W+1)'(subv);
        sv   = full[W-1:0];
        cv   = full[W];
        vv   = (av[W-1] == bev[W-1]) && (sv[W-1] != av[W-1]);
    endfunction

    // ------------------------------------------------------------------ model
    bit           m_busy = 1'b0;
    bit           m_done = 1'b0;
    int           m_left = 0;
    int           txn    = 0;
    logic [W-1:0] m_a_out = '0, m_b_eff = '0, m_s = '0;
    logic         m_cout = 1'b0, m_ovf = 1'b0;
    logic [W-1:0] p_s, p_a, p_b;
    logic         p_cout, p_ovf, p_sub;

    always @(posedge clk) begin : model
        logic [W-1:0] ts, tbe;
        logic         tc, tv;
        if (rst) begin
            m_busy = 1'b0; m_done = 1'b0; m_left = 0;
            m_a_out = '0; m_b_eff = '0; m_s = '0; m_cout = 1'b0; m_ovf = 1'b0;
        end else if (m_done) begin
            m_done = 1'b0;
        end else if (m_busy) begin
            m_left--;
            if (m_left == 0) begin
                m_busy = 1'b0;
                m_done = 1'b1;
                m_s    = p_s;
                m_cout = p_cout;
                m_ovf  = p_ovf;
                txn++;
                $display("txn %0d: a=%h b=%h sub=%b -> s=%h cout=%b ovf=%b",
                         txn, p_a, p_b, p_sub, m_s, m_cout, m_ovf);
            end
        end else if (start) begin
            model_calc(a, b, sub, ts, tc, tv, tbe);
            m_a_out = a;
            m_b_eff = tbe;
            p_s = ts; p_cout = tc; p_ovf = tv;
            p_a = a; p_b = b; p_sub = sub;
            m_busy = 1'b1;
            m_left = W;
        end
    end

    // ---------------------------------------------------------------- compare
    always @(negedge clk) begin
        if (chk_en) begin
            check("busy", 32'(busy), 32'(m_busy));
            check("done", 32'(done), 32'(m_done));
            check("a_out", 32'(a_out), 32'(m_a_out));
            check("b_eff", 32'(b_eff), 32'(m_b_eff));
            if (!m_busy) begin
                check("s", 32'(s), 32'(m_s));
                check("cout", 32'(cout), 32'(m_cout));
`ifdef OVF_FLAG_EN
                check("ovf", 32'(ovf), 32'(m_ovf));
`endif
            end
        end
    end

    // -------------------------------------------------------------- directed
    // The caller is at a falling edge with the DUT idle.
    task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic subv,
                          input logic [W-1:0] es, input logic ec, input logic [W-1:0] ebe,
                          input logic ev);
        logic [W-1:0] ms, mbe;
        logic         mc, mv;
        int           k;
        model_calc(av, bv, subv, ms, mc, mv, mbe);
        check("lit_model_s", 32'(ms), 32'(es));
        check("lit_model_cout", 32'(mc), 32'(ec));
        check("lit_model_beff", 32'(mbe), 32'(ebe));
        check("lit_model_ovf", 32'(mv), 32'(ev));
        a = av; b = bv; sub = subv; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        check("lit_busy_after_accept", 32'(busy), 32'd1);
        while (!done && k < 3 * W) begin
            @(negedge clk);
            k++;
        end
        if (!done) begin
            check("lit_done_timeout", 32'(done), 32'd1);
        end else begin
            check("lit_latency", 32'(k), 32'(W));
            check("lit_s", 32'(s), 32'(es));
            check("lit_cout", 32'(cout), 32'(ec));
            check("lit_a_out", 32'(a_out), 32'(av));
            check("lit_b_eff", 32'(b_eff), 32'(ebe));
`ifdef OVF_FLAG_EN
            check("lit_ovf", 32'(ovf), 32'(ev));
`endif
        end
        @(negedge clk);
        check("lit_done_one_cycle", 32'(done), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int n;
        rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0;
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        check("lit_reset_busy", 32'(busy), 32'd0);
        check("lit_reset_s", 32'(s), 32'd0);
        check("lit_reset_a_out", 32'(a_out), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        run_op(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 8'h01, 1'b1);
        run_op(8'h81, 8'h02, 1'b1, 8'h7F, 1'b1, 8'hFD, 1'b1);
        run_op(8'h01, 8'h7E, 1'b0, 8'h7F, 1'b0, 8'h7E, 1'b0);
        run_op(8'h05, 8'h05, 1'b1, 8'h00, 1'b1, 8'hFA, 1'b0);

        // A start pulse while busy must be ignored.
        a = 8'h10; b = 8'h20; sub = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (!done && k < 3 * W) begin
            start = (k == 3);
            if (k == 3) begin
                a = 8'hFF; b = 8'hFF;
            end
            @(negedge clk);
            k++;
        end
        start = 1'b0;
        check("busy_start_latency", 32'(k), 32'(W));
        check("busy_start_s", 32'(s), 32'h30);
        check("busy_start_a_out", 32'(a_out), 32'h10);
        check("busy_start_b_eff", 32'(b_eff), 32'h20);
        n = 0;
        repeat (2 * W) begin
            @(negedge clk);
            if (done) n++;
        end
        check("busy_start_extra_done", 32'(n), 32'd0);

        // Reset in the middle of an operation.
        a = 8'h7F; b = 8'h01; sub = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_done", 32'(done), 32'd0);
        check("rst_mid_s", 32'(s), 32'd0);
        check("rst_mid_cout", 32'(cout), 32'd0);
        check("rst_mid_a_out", 32'(a_out), 32'd0);
        check("rst_mid_b_eff", 32'(b_eff), 32'd0);
        n = 0;
        repeat (2 * W) begin
            @(negedge clk);
            if (done) n++;
        end
        check("rst_mid_no_done", 32'(n), 32'd0);
        run_op(8'h40, 8'h3F, 1'b0, 8'h7F, 1'b0, 8'h3F, 1'b0);

        // Randomized traffic, with occasional resets.
        repeat (4000) begin
            @(negedge clk);
            rst   = ($urandom_range(0, 99) == 0);
            start = ($urandom_range(0, 2) == 0);
            a     = W'($urandom);
            b     = W'($urandom);
            sub   = 1'($urandom);
        end
        // Hold start high continuously to exercise back-to-back throughput.
        rst = 1'b0;
        repeat (300) begin
            @(negedge clk);
            start = 1'b1;
            a     = W'($urandom);
            b     = W'($urandom);
            sub   = 1'($urandom);
        end
        @(negedge clk);
        start = 1'b0;
        repeat (3 * W) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
